// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, history limit and carrier direction
// for the pwm_dt_bank complementary PWM generator.
package pwm_pkg;
  localparam int CNT_W_DEF = 10;
  localparam int DT_W_DEF  = 6;

  typedef enum logic {UP, DOWN} dir_e;

  // Longest window the deadtime stage ever needs: d+1 with d at max.
  function automatic int hist_lim(input int dt_w);
    return 1 << dt_w;
  endfunction
endpackage

// File: rtl/pwm_dt_insert.sv
// pwm_dt_insert: per-channel deadtime stage; a saturating run
// length of identical raw samples stands in for the d+1 window.
module pwm_dt_insert
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            raw,
  input  logic [DT_W-1:0] d,
  output logic            s,
  output logic            nots
);
  localparam int RW = DT_W + 1;
  localparam logic [RW-1:0] LIM = RW'(hist_lim(DT_W));

  logic          primed_q;
  logic          last_q;
  logic          s_q;
  logic          nots_q;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;
  logic [RW-1:0] need;
  logic          hit;

  // The first sample after reset is the reset raw value: not trusted.
  always_comb begin
    need  = {1'b0, d} + RW'(1);
    run_d = RW'(1);
    if (!primed_q)
      run_d = '0;
    else if (raw == last_q && run_q != '0)
      run_d = (run_q >= LIM) ? LIM : run_q + RW'(1);
    hit = (run_d >= need);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= 1'b0;
      last_q   <= 1'b0;
      run_q    <= '0;
      s_q      <= 1'b0;
      nots_q   <= 1'b0;
    end else if (ce) begin
      primed_q <= 1'b1;
      last_q   <= raw;
      run_q    <= run_d;
      s_q      <= raw & hit;
      nots_q   <= ~raw & hit;
    end
  end

  assign s    = s_q;
  assign nots = nots_q;
endmodule

// File: rtl/pwm_dt_bank.sv
// pwm_dt_bank: N-channel complementary PWM with shadowed period/duty/
// deadtime; PWM_CENTER_ALIGNED_EN selects a triangular carrier.
module pwm_dt_bank
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DT_W     = DT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [CNT_W-1:0]          period,
  input  logic [CHANNELS*CNT_W-1:0] duty,
  input  logic [DT_W-1:0]           deadtime,
  input  logic                      load,
  output logic [CHANNELS-1:0]       s,
  output logic [CHANNELS-1:0]       nots,
  output logic                      interrupt
);
  typedef logic [CHANNELS-1:0][CNT_W-1:0] duty_t;

  logic [CNT_W-1:0]    p_sh_q;
  logic [CNT_W-1:0]    p_act_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [DT_W-1:0]     d_sh_q;
  logic [DT_W-1:0]     d_act_q;
  duty_t               duty_sh_q;
  duty_t               duty_act_q;
  logic [CHANNELS-1:0] raw_q;
  logic [CHANNELS-1:0] raw_d;
  logic                irq_q;
  logic                wrap;

`ifdef PWM_CENTER_ALIGNED_EN
  dir_e dir_q;
  dir_e dir_d;

  // Wrap is the valley: the step that lands on zero.
  always_comb begin
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (dir_q == UP && cnt_q < p_act_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      if (cnt_q != '0)
        cnt_d = cnt_q - CNT_W'(1);
      dir_d = DOWN;
    end
    if (cnt_d == '0)
      dir_d = UP;
    wrap = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dir_q <= UP;
    else if (ce)
      dir_q <= dir_d;
  end
`else
  always_comb begin
    wrap  = (cnt_q >= p_act_q);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  end
`endif

  always_comb begin
    raw_d = '0;
    for (int i = 0; i < CHANNELS; i++)
      raw_d[i] = (cnt_q < duty_act_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_sh_q     <= '0;
      d_sh_q     <= '0;
      duty_sh_q  <= '0;
      p_act_q    <= '0;
      d_act_q    <= '0;
      duty_act_q <= '0;
      cnt_q      <= '0;
      raw_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (load) begin
        p_sh_q    <= period;
        d_sh_q    <= deadtime;
        duty_sh_q <= duty;
      end
      if (ce) begin
        cnt_q <= cnt_d;
        raw_q <= raw_d;
        if (wrap) begin
          p_act_q    <= p_sh_q;
          d_act_q    <= d_sh_q;
          duty_act_q <= duty_sh_q;
        end
      end
      irq_q <= ce & wrap;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_dt_insert #(
      .DT_W(DT_W)
    ) u_dt (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .raw (raw_q[i]),
      .d   (d_act_q),
      .s   (s[i]),
      .nots(nots[i])
    );
  end

  assign interrupt = irq_q;
endmodule

// File: tb/tb_pwm_dt_bank.sv
// tb_pwm_dt_bank: scoreboard bench; a phase/history reference model
// predicts s, nots and interrupt for every clk.
module tb_pwm_dt_bank;
  localparam int CH  = 2;
  localparam int CW  = 10;
  localparam int DW  = 6;
  localparam int UNK = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             ce;
  logic             load;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic [DW-1:0]    deadtime;
  logic [CH-1:0]    s;
  logic [CH-1:0]    nots;
  logic             interrupt;

  int checks = 0;
  int errors = 0;

  pwm_dt_bank #(
    .CHANNELS(CH),
    .CNT_W   (CW),
    .DT_W    (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .period   (period),
    .duty     (duty),
    .deadtime (deadtime),
    .load     (load),
    .s        (s),
    .nots     (nots),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] s;
    logic [CH-1:0] n;
    logic          irq;
  } exp_t;

  exp_t sbq[$];

  // Reference model: carrier as a phase within the period, deadtime
  // as an explicit list of past raw samples (newest first).
  int            m_P, m_d, h_P, h_d, m_ph, mc;
  int            m_dut[CH];
  int            h_dut[CH];
  int            m_raw[CH];
  int            hist[CH][$];
  logic [CH-1:0] m_s, m_n;
  logic          m_irq;
  bit            a1, a0;

  function automatic int carrier(input int ph, input int p);
`ifdef PWM_CENTER_ALIGNED_EN
    return (ph <= p) ? ph : 2 * p - ph;
`else
    return ph + 0 * p;
`endif
  endfunction

  function automatic int plen(input int p);
`ifdef PWM_CENTER_ALIGNED_EN
    return (p == 0) ? 1 : 2 * p;
`else
    return p + 1;
`endif
  endfunction

  always @(posedge clk) begin
    m_irq = 1'b0;
    if (rst) begin
      m_P = 0; m_d = 0; h_P = 0; h_d = 0; m_ph = 0;
      m_s = '0; m_n = '0;
      for (int c = 0; c < CH; c++) begin
        m_dut[c] = 0; h_dut[c] = 0; m_raw[c] = UNK;
        hist[c].delete();
      end
    end else begin
      if (ce) begin
        for (int c = 0; c < CH; c++) begin
          hist[c].push_front(m_raw[c]);
          if (hist[c].size() > 80) void'(hist[c].pop_back());
          a1 = (hist[c].size() >= m_d + 1);
          a0 = a1;
          for (int k = 0; k <= m_d && k < hist[c].size(); k++) begin
            if (hist[c][k] != 1) a1 = 1'b0;
            if (hist[c][k] != 0) a0 = 1'b0;
          end
          m_s[c] = a1;
          m_n[c] = a0;
        end
        mc = carrier(m_ph, m_P);
        for (int c = 0; c < CH; c++)
          m_raw[c] = (mc < m_dut[c]) ? 1 : 0;
        m_ph = (m_ph + 1) % plen(m_P);
        if (m_ph == 0) begin
          m_P = h_P; m_d = h_d; m_dut = h_dut;
          m_irq = 1'b1;
        end
      end
      if (load) begin
        h_P = int'(period);
        h_d = int'(deadtime);
        for (int c = 0; c < CH; c++) h_dut[c] = int'(duty[c*CW +: CW]);
      end
    end
    sbq.push_back('{s: m_s, n: m_n, irq: m_irq});
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_empty t=%0t no expected entry", $time);
      end else begin
        e = sbq.pop_front();
        if (s !== e.s || nots !== e.n || interrupt !== e.irq) begin
          errors++;
          $display("FAIL sb t=%0t s=%b want %b nots=%b want %b irq=%b want %b",
                   $time, s, e.s, nots, e.n, interrupt, e.irq);
        end
        checks++;
        if ((s & nots) !== '0) begin
          errors++;
          $display("FAIL overlap t=%0t s=%b nots=%b want no common bit", $time, s, nots);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic cfg(input int p, input int d0, input int d1, input int dt);
    period   = CW'(p);
    duty     = {CW'(d1), CW'(d0)};
    deadtime = DW'(dt);
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (m_ph != v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cnt", int'(m_ph == v), 1);
  endtask

  task automatic measure(input int n, input bit tog,
                         output int s0, output int n0, output int s1,
                         output int n1, output int ic);
    s0 = 0; n0 = 0; s1 = 0; n1 = 0; ic = 0;
    repeat (n) begin
      @(negedge clk);
      s0 += int'(s[0]); n0 += int'(nots[0]);
      s1 += int'(s[1]); n1 += int'(nots[1]);
      ic += int'(interrupt);
      if (tog) ce = ~ce;
    end
  endtask

  int cs0, cn0, cs1, cn1, ci;

  initial begin
    rst = 1'b1; ce = 1'b0; load = 1'b0;
    period = '0; duty = '0; deadtime = '0;
    #1;
    chk("rst_s", int'(s), 0);
    chk("rst_nots", int'(nots), 0);
    chk("rst_irq", int'(interrupt), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; ce = 1'b1;

    cfg(9, 3, 10, 0);
    repeat (30) @(negedge clk);
    measure(10, 1'b0, cs0, cn0, cs1, cn1, ci);
    chk("d0_s0", cs0, 3); chk("d0_n0", cn0, 7);
    chk("sat_s1", cs1, 10); chk("sat_n1", cn1, 0);
    chk("d0_irq", ci, 1);

    cfg(9, 3, 10, 2);
    repeat (30) @(negedge clk);
    measure(10, 1'b0, cs0, cn0, cs1, cn1, ci);
    chk("d2_s0", cs0, 1); chk("d2_n0", cn0, 5);
    chk("d2_s1", cs1, 10); chk("d2_irq", ci, 1);

    cfg(9, 1, 10, 2);
    repeat (30) @(negedge clk);
    measure(10, 1'b0, cs0, cn0, cs1, cn1, ci);
    chk("short_s0", cs0, 0);

    cfg(9, 3, 10, 0);
    repeat (30) @(negedge clk);
    wait_cnt(4);
    cfg(9, 6, 10, 0);
    repeat (25) @(negedge clk);
    measure(10, 1'b0, cs0, cn0, cs1, cn1, ci);
    chk("shadow_s0", cs0, 6);

    wait_cnt(9);
    cfg(9, 2, 10, 0);
    repeat (30) @(negedge clk);
    measure(10, 1'b0, cs0, cn0, cs1, cn1, ci);
    chk("wrapload_s0", cs0, 2);

    cfg(9, 3, 10, 0);
    repeat (30) @(negedge clk);
    repeat (40) begin
      @(negedge clk);
      ce = ~ce;
    end
    measure(20, 1'b1, cs0, cn0, cs1, cn1, ci);
    chk("ce2_s0", cs0, 6); chk("ce2_n0", cn0, 14);
    chk("ce2_irq", ci, 1);
    ce = 1'b1;

    repeat (30) @(negedge clk);
    wait_cnt(5);
    rst = 1'b1;
    #1;
    chk("arst_s", int'(s), 0);
    chk("arst_nots", int'(nots), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst1_s", int'(s), 0);
    chk("post_rst1_n", int'(nots), 0);
    @(negedge clk);
    chk("post_rst2_n", int'(nots), 3);

    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      load = 1'b0;
      rst  = 1'b0;
      if (it % 400 < 100)      ce = 1'b1;
      else if (it % 400 < 200) ce = ~ce;
      else                     ce = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) begin
        period   = CW'($urandom_range(0, 15));
        duty     = {CW'($urandom_range(0, int'(period) + 2)),
                    CW'($urandom_range(0, int'(period) + 2))};
        deadtime = DW'($urandom_range(0, 5));
        load     = 1'b1;
      end
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
    end
    @(negedge clk);
    load = 1'b0; rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
